spy_fifo_reader: RTL and testbench

Drain-side companion to the spy capture FIFO. Pops captured records from the FIFO pop interface, holds each record and serializes it as `DATA_WIDTH/OUT_WIDTH` narrower beats on a valid/ready stream toward the trace export path. It uses back-to-back pops so there is no idle cycle between records, and it counts the records drained.

---
 rtl/spy_fifo_reader.sv | 88 ++++++++
 tb/tb_spy_fifo_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spy_fifo_reader.sv
// Drains records from the spy capture FIFO and serializes each one, LSB beat
// first, onto a valid/ready stream; counts fully transmitted records.
module spy_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  empty_i,
    output logic                  pop_o,
    input  logic [DATA_WIDTH-1:0] pop_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [OUT_WIDTH-1:0]  m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic [31:0]           count_o
);
    localparam int unsigned BEATS  = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [0:0]            state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [DATA_WIDTH-1:0] rec_q, rec_d;
    logic [31:0]           count_q, count_d;
    logic                  accept;

    // Stream outputs decode registered state only, so they hold under backpressure.
    assign m_valid_o = (state_q == SEND);
    assign m_last_o  = (state_q == SEND) && (beat_q == LAST_BEAT);
    assign busy_o    = (state_q == SEND);
    assign count_o   = count_q;
    assign accept    = m_valid_o & m_ready_i;

    // Pop when idle, or back-to-back on the last-beat handshake so records abut.
    assign pop_o = reset_n & enable_i & ~empty_i
                 & ((state_q == IDLE) | (accept & m_last_o));

    always_comb begin
        m_data_o = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if ((state_q == SEND) && (beat_q == BEAT_W'(i))) begin
                m_data_o = rec_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rec_d   = rec_q;
        count_d = count_q;
        if (accept) begin
            if (m_last_o) begin
                count_d = count_q + 32'd1;
                beat_d  = '0;
                state_d = IDLE;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
        if (pop_o) begin
            rec_d   = pop_data_i;
            beat_d  = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rec_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rec_q   <= rec_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_spy_fifo_reader.sv
// Bench for spy_fifo_reader: a queue-based FIFO and beat-stream model checked
// against a 64/32 instance and a single-beat 64/64 instance.
module tb_spy_fifo_reader;
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n;

    logic        en_a, emp_a, rdy_a, pop_a, valid_a, last_a, busy_a;
    logic [63:0] pd_a;
    logic [31:0] data_a, count_a;
    logic        en_b, emp_b, rdy_b, pop_b, valid_b, last_b, busy_b;
    logic [63:0] pd_b, data_b;
    logic [31:0] count_b;

    spy_fifo_reader #(.DATA_WIDTH(64), .OUT_WIDTH(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable_i(en_a), .empty_i(emp_a),
        .pop_o(pop_a), .pop_data_i(pd_a), .m_valid_o(valid_a), .m_ready_i(rdy_a),
        .m_data_o(data_a), .m_last_o(last_a), .busy_o(busy_a), .count_o(count_a)
    );

    spy_fifo_reader #(.DATA_WIDTH(64), .OUT_WIDTH(64)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable_i(en_b), .empty_i(emp_b),
        .pop_o(pop_b), .pop_data_i(pd_b), .m_valid_o(valid_b), .m_ready_i(rdy_b),
        .m_data_o(data_b), .m_last_o(last_b), .busy_o(busy_b), .count_o(count_b)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          sel      = 1'b0;
    logic [63:0] fifo_q[$];
    beat_t       exp_q[$];
    int unsigned e_count[2];

    // Snapshot layout: pop, valid, last, busy, data[63:0], count[31:0]
    logic [99:0] o_snap, e_snap;
    logic        o_pop, o_valid, o_last;
    logic [63:0] o_data;
    logic [31:0] o_count;

    // One clock: drive the selected instance from the FIFO model, sample, advance model.
    task automatic run_cycle(input bit rdy, input bit en);
        logic        emp, e_hold, e_last, acc_last, e_pop;
        logic [63:0] pd, e_data;
        beat_t       b;
        emp = (fifo_q.size() == 0);
        pd  = emp ? 64'd0 : fifo_q[0];
        if (!sel) begin
            en_a = en; emp_a = emp; rdy_a = rdy; pd_a = pd;
            en_b = 1'b0; emp_b = 1'b1; rdy_b = 1'b0; pd_b = 64'd0;
        end else begin
            en_b = en; emp_b = emp; rdy_b = rdy; pd_b = pd;
            en_a = 1'b0; emp_a = 1'b1; rdy_a = 1'b0; pd_a = 64'd0;
        end
        #1;
        if (!sel) o_snap = {pop_a, valid_a, last_a, busy_a, 32'd0, data_a, count_a};
        else      o_snap = {pop_b, valid_b, last_b, busy_b, data_b, count_b};
        o_pop   = o_snap[99];
        o_valid = o_snap[98];
        o_last  = o_snap[97];
        o_data  = o_snap[95:32];
        o_count = o_snap[31:0];

        e_hold = (exp_q.size() != 0);
        e_last = 1'b0;
        e_data = 64'd0;
        if (e_hold) begin
            e_last = exp_q[0].last;
            e_data = exp_q[0].data;
        end
        acc_last = e_hold && rdy && e_last;
        e_pop    = en && !emp && (!e_hold || acc_last);
        e_snap   = {e_pop, e_hold, e_last, e_hold, e_data, 32'(e_count[sel])};

        if (e_hold && rdy) void'(exp_q.pop_front());
        if (acc_last) e_count[sel] = e_count[sel] + 1;
        if (e_pop) begin
            if (sel) begin
                b.data = pd; b.last = 1'b1; exp_q.push_back(b);
            end else begin
                b.data = {32'd0, pd[31:0]};  b.last = 1'b0; exp_q.push_back(b);
                b.data = {32'd0, pd[63:32]}; b.last = 1'b1; exp_q.push_back(b);
            end
        end
        if (o_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        e_count[0] = 0;
        e_count[1] = 0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        fifo_q.push_back(64'hDEAD_BEEF_0000_0001);
        reset_n = 1'b0; en_a = 1'b1; emp_a = 1'b0; pd_a = fifo_q[0]; rdy_a = 1'b1;
        #1;
        n_checks++;
        if (pop_a !== 1'b0) $display("FAIL reset_pop: got %b want 0", pop_a); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        fifo_q.delete();
        run_cycle(1'b1, 1'b0);
        n_checks++;
        if (o_snap !== 100'd0) $display("FAIL reset_state_a: got %h want 0", o_snap); else n_pass++;
        n_checks++;
        if ({valid_b, last_b, busy_b, data_b, count_b} !== 99'd0)
            $display("FAIL reset_state_b: got %h want 0", {valid_b, last_b, busy_b, data_b, count_b});
        else n_pass++;
    endtask

    task automatic test_single();
        sel = 1'b0;
        fifo_q.push_back(64'h1122334455667788);
        for (int c = 0; c < 4; c++) begin
            run_cycle(1'b1, 1'b1);
            n_checks++;
            if (o_snap !== e_snap) $display("FAIL single_c%0d: got %h want %h", c, o_snap, e_snap);
            else n_pass++;
            n_checks++;
            case (c)
                0: if ({o_pop, o_valid} !== 2'b10) $display("FAIL single_pop: got %b want 10", {o_pop, o_valid}); else n_pass++;
                1: if ({o_valid, o_last, o_data} !== {2'b10, 64'h55667788})
                       $display("FAIL single_beat0: got %h want 55667788 last 0", o_data); else n_pass++;
                2: if ({o_valid, o_last, o_data} !== {2'b11, 64'h11223344})
                       $display("FAIL single_beat1: got %h want 11223344 last 1", o_data); else n_pass++;
                default: if ({o_valid, o_snap[96], o_count} !== {2'b00, 32'd1})
                       $display("FAIL single_done: got busy %b count %0d want 0 1", o_snap[96], o_count); else n_pass++;
            endcase
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pops, valids;
        sel = 1'b0;
        pops = '0; valids = '0;
        for (int r = 0; r < 3; r++) fifo_q.push_back({$urandom, $urandom});
        for (int c = 0; c < 8; c++) begin
            run_cycle(1'b1, 1'b1);
            pops[c]   = o_pop;
            valids[c] = o_valid;
            n_checks++;
            if (o_snap !== e_snap) $display("FAIL b2b_c%0d: got %h want %h", c, o_snap, e_snap);
            else n_pass++;
        end
        n_checks++;
        if (pops !== 8'b0001_0101) $display("FAIL b2b_pops: got %b want 00010101", pops); else n_pass++;
        n_checks++;
        if (valids !== 8'b0111_1110) $display("FAIL b2b_valids: got %b want 01111110", valids); else n_pass++;
        n_checks++;
        if (o_count !== 32'd4) $display("FAIL b2b_count: got %0d want 4", o_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        sel = 1'b0;
        fifo_q.push_back(64'hA5A5_0F0F_C3C3_9696);
        fifo_q.push_back(64'h0123_4567_89AB_CDEF);
        run_cycle(1'b1, 1'b1);
        held = 64'h0000_0000_C3C3_9696;
        for (int c = 0; c < 5; c++) begin
            run_cycle(1'b0, 1'b1);
            n_checks++;
            if (o_snap !== e_snap) $display("FAIL bp_stall_c%0d: got %h want %h", c, o_snap, e_snap);
            else n_pass++;
            n_checks++;
            if ({o_pop, o_valid, o_last, o_data} !== {3'b010, held})
                $display("FAIL bp_hold_c%0d: got pop %b data %h last %b want 0 %h 0", c, o_pop, o_data, o_last, held);
            else n_pass++;
        end
        for (int c = 0; c < 5; c++) begin
            run_cycle(1'b1, 1'b1);
            n_checks++;
            if (o_snap !== e_snap) $display("FAIL bp_drain_c%0d: got %h want %h", c, o_snap, e_snap);
            else n_pass++;
        end
        n_checks++;
        if (o_count !== 32'd6) $display("FAIL bp_count: got %0d want 6", o_count); else n_pass++;
    endtask

    task automatic test_empty();
        bit seen;
        sel = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            run_cycle(1'b1, 1'b1);
            if (o_pop || o_valid) seen = 1'b1;
            n_checks++;
            if (o_snap !== e_snap) $display("FAIL empty_c%0d: got %h want %h", c, o_snap, e_snap);
            else n_pass++;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL empty_activity: got %b want 0", seen); else n_pass++;
    endtask

    task automatic test_enable();
        sel = 1'b0;
        fifo_q.push_back(64'hFEED_FACE_CAFE_F00D);
        fifo_q.push_back(64'h1357_9BDF_2468_ACE0);
        run_cycle(1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b1, 1'b0);
            n_checks++;
            if (o_snap !== e_snap) $display("FAIL enable_c%0d: got %h want %h", c, o_snap, e_snap);
            else n_pass++;
        end
        n_checks++;
        if ({o_pop, o_valid} !== 2'b00 || fifo_q.size() != 1)
            $display("FAIL enable_stop: got pop %b valid %b fifo %0d want 0 0 1", o_pop, o_valid, fifo_q.size());
        else n_pass++;
        fifo_q.delete();
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        fifo_q.push_back(64'h7777_6666_5555_4444);
        fifo_q.push_back(64'h3333_2222_1111_0000);
        run_cycle(1'b1, 1'b1);
        reset_n = 1'b0; en_a = 1'b1; emp_a = 1'b0; pd_a = fifo_q[0]; rdy_a = 1'b1;
        #1;
        n_checks++;
        if (pop_a !== 1'b0) $display("FAIL rstmid_pop: got %b want 0", pop_a); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            run_cycle(1'b1, 1'b0);
            n_checks++;
            if ({o_valid, o_last, o_data, o_count} !== 98'd0)
                $display("FAIL rstmid_c%0d: got valid %b data %h count %0d want 0 0 0", c, o_valid, o_data, o_count);
            else n_pass++;
        end
        fifo_q.delete();
    endtask

    task automatic test_beats1();
        logic [5:0] valids, lasts;
        sel = 1'b1;
        valids = '0; lasts = '0;
        for (int r = 0; r < 4; r++) fifo_q.push_back({$urandom, $urandom});
        for (int c = 0; c < 6; c++) begin
            run_cycle(1'b1, 1'b1);
            valids[c] = o_valid;
            lasts[c]  = o_last;
            n_checks++;
            if (o_snap !== e_snap) $display("FAIL beats1_c%0d: got %h want %h", c, o_snap, e_snap);
            else n_pass++;
        end
        n_checks++;
        if ({valids, lasts} !== {6'b011110, 6'b011110})
            $display("FAIL beats1_stream: got valid %b last %b want 011110 011110", valids, lasts);
        else n_pass++;
        n_checks++;
        if (o_count !== 32'd4) $display("FAIL beats1_count: got %0d want 4", o_count); else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int seg = 0; seg < 6; seg++) begin
            sel = seg[0];
            for (int c = 0; c < 64; c++) begin
                if (fifo_q.size() < 4 && ($urandom % 3) == 0) fifo_q.push_back({$urandom, $urandom});
                if (c < 60) run_cycle(($urandom % 4) != 0, ($urandom % 8) != 0);
                else begin
                    if (c == 60) fifo_q.delete();
                    run_cycle(1'b1, 1'b0);
                end
                n_checks++;
                if (o_snap !== e_snap) begin
                    if (errs < 10) $display("FAIL random_s%0d_c%0d: got %h want %h", seg, c, o_snap, e_snap);
                    errs++;
                end else n_pass++;
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        en_a = 1'b0; emp_a = 1'b1; rdy_a = 1'b0; pd_a = 64'd0;
        en_b = 1'b0; emp_b = 1'b1; rdy_b = 1'b0; pd_b = 64'd0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_enable();
        test_reset_mid();
        test_beats1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end
endmodule
